// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline control bit positions, lane indices and default widths
package pipe_pkg;
   localparam int CTRL_MEMREAD     = 0;
   localparam int CTRL_MEMWRITE    = 1;
   localparam int CTRL_REGWRITE    = 2;
   localparam int CTRL_MEMTOREG_LO = 3;
   localparam int LANE_ALU         = 0;
   localparam int LANE_REGB        = 1;
   localparam int LANE_PC4         = 2;
   localparam int DEF_CTRL_W       = 5;
   localparam int DEF_RD_W         = 5;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_NUM_DATA     = 3;
   localparam int DEF_CNT_W        = 16;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous active-low clear
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   // count up on inc, stick at all-ones
   always_ff @(posedge clk)
      if (!clr_n) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM pipeline register with 2-entry skid buffer, flush and stall counter
module ex_mem_skid_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = DEF_CTRL_W,
   parameter int RD_W     = DEF_RD_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_DATA = DEF_NUM_DATA,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [RD_W-1:0]            out_rd,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [1:0]                 occupancy,
   output logic [CNT_W-1:0]           stall_cnt
);
   logic                       h_valid, s_valid;
   logic [CTRL_W-1:0]          h_ctrl, s_ctrl;
   logic [RD_W-1:0]            h_rd, s_rd;
   logic [NUM_DATA*DATA_W-1:0] h_data, s_data;
   logic                       accept, fire;

   // in_ready comes straight from the skid valid flop, so out_ready never reaches it combinationally
   assign in_ready  = ~s_valid;
   assign accept    = in_valid & in_ready;
   assign fire      = h_valid & out_ready;
   assign out_valid = h_valid;
   assign out_ctrl  = h_valid ? h_ctrl : '0;
   assign out_rd    = h_valid ? h_rd : '0;
   assign out_data  = h_data;
   assign occupancy = {h_valid & s_valid, h_valid ^ s_valid};

   // head/skid update: fill head first, spill to skid under back-pressure, refill head from skid
   always_ff @(posedge clk)
      if (!reset) begin
         h_valid <= 1'b0;
         h_ctrl  <= '0;
         h_rd    <= '0;
         h_data  <= '0;
         s_valid <= 1'b0;
         s_ctrl  <= '0;
         s_rd    <= '0;
         s_data  <= '0;
      end else if (flush) begin
         h_valid <= 1'b0;
         h_ctrl  <= '0;
         s_valid <= 1'b0;
         s_ctrl  <= '0;
      end else if (!h_valid || (!s_valid && fire)) begin
         if (accept) begin
            h_valid <= 1'b1;
            h_ctrl  <= in_ctrl;
            h_rd    <= in_rd;
            h_data  <= in_data;
         end else h_valid <= 1'b0;
      end else if (!s_valid) begin
         if (accept) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_rd    <= in_rd;
            s_data  <= in_data;
         end
      end else if (fire) begin
         h_ctrl  <= s_ctrl;
         h_rd    <= s_rd;
         h_data  <= s_data;
         s_valid <= 1'b0;
      end

   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall (
      .clk  (clk),
      .clr_n(reset),
      .inc  (h_valid & ~out_ready),
      .cnt  (stall_cnt)
   );
endmodule
